// File: rtl/arb_pkg.sv
// Shared types and constants for the shared-data-memory arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    ACK    = 2'd3
  } arb_state_e;

  // Cycles between the DRAM clocking in an address and q being valid.
  localparam int unsigned READ_LAT = 1;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned idw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate requests so the slot after 'last'
// is bit 0, then take the lowest set bit and un-rotate the index.
module rr_pick #(
  parameter int unsigned N_CORES = 4,
  parameter int unsigned IDW     = 2
) (
  input  logic [N_CORES-1:0] req,
  input  logic [IDW-1:0]     last,
  output logic [IDW-1:0]     winner,
  output logic               any
);

  logic [N_CORES-1:0] rot;
  int unsigned        start;
  int unsigned        pos;

  always_comb begin
    start = (32'(last) + 32'd1) % N_CORES;
    for (int unsigned k = 0; k < N_CORES; k++) begin
      rot[k] = req[(start + k) % N_CORES];
    end
    pos = 0;
    for (int k = int'(N_CORES) - 1; k >= 0; k--) begin
      if (rot[k]) pos = 32'(k);
    end
    winner = IDW'((start + pos) % N_CORES);
    any    = |req;
  end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one single-port DRAM between N_CORES cores;
// one access at a time, completion signalled by a one-cycle acq pulse.
module dram_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N_CORES = 4,
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 8
) (
  input  logic                    CLK,
  input  logic                    rst_n,
  input  logic [N_CORES-1:0]      req_rd,
  input  logic [N_CORES-1:0]      req_wr,
  input  logic [N_CORES*AW-1:0]   req_addr,
  input  logic [N_CORES*DW-1:0]   req_wdata,
  output logic [N_CORES-1:0]      acq,
  output logic [DW-1:0]           rdata,
  output logic [AW-1:0]           mem_addr,
  output logic [DW-1:0]           mem_wdata,
  output logic                    mem_wren,
  input  logic [DW-1:0]           mem_q,
  output logic                    busy,
  output logic [idw(N_CORES)-1:0] gnt_id
);

  localparam int unsigned IDW = idw(N_CORES);
  localparam int unsigned CW  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  arb_state_e         state;
  logic [IDW-1:0]     last;
  logic               op_wr;
  logic [CW-1:0]      wait_cnt;
  logic [N_CORES-1:0] req;
  logic [IDW-1:0]     winner;
  logic               any;

  // A core asserting both lines counts once; the write takes precedence below.
  assign req = req_rd | req_wr;

  rr_pick #(
    .N_CORES (N_CORES),
    .IDW     (IDW)
  ) u_rr_pick (
    .req    (req),
    .last   (last),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= IDW'(N_CORES - 1);
      gnt_id    <= '0;
      op_wr     <= 1'b0;
      wait_cnt  <= '0;
      acq       <= '0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wren  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      acq      <= '0;
      mem_wren <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any) begin
            gnt_id    <= winner;
            last      <= winner;
            op_wr     <= req_wr[winner];
            mem_addr  <= req_addr[32'(winner)*AW +: AW];
            mem_wdata <= req_wdata[32'(winner)*DW +: DW];
            mem_wren  <= req_wr[winner];
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          wait_cnt <= CW'(READ_LAT - 1);
          if (op_wr) begin
            acq   <= N_CORES'(1) << gnt_id;
            state <= ACK;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // mem_addr is held, so q stays valid until captured
          if (wait_cnt == '0) begin
            rdata <= mem_q;
            acq   <= N_CORES'(1) << gnt_id;
            state <= ACK;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        ACK: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: a 4-core and a 1-core instance, each on its own DRAM model.
module tb_dram_arbiter;

  localparam int unsigned NC = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic              rst_n;
  logic              init_mem;
  logic [NC-1:0]     req_rd, req_wr, acq;
  logic [NC*AW-1:0]  req_addr;
  logic [NC*DW-1:0]  req_wdata;
  logic [DW-1:0]     rdata, mem_wdata, mem_q;
  logic [AW-1:0]     mem_addr;
  logic              mem_wren, busy;
  logic [1:0]        gnt_id;

  logic              s_rd, s_wr, s_acq, s_wren, s_busy, s_gnt;
  logic [7:0]        s_addr, s_wdata, s_rdata, s_maddr, s_mwdata, s_q;

  dram_arbiter #(.N_CORES(NC), .AW(AW), .DW(DW)) u_dut4 (
    .CLK(CLK), .rst_n(rst_n), .req_rd(req_rd), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .acq(acq), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_q(mem_q), .busy(busy), .gnt_id(gnt_id)
  );

  dram_arbiter #(.N_CORES(1), .AW(AW), .DW(DW)) u_dut1 (
    .CLK(CLK), .rst_n(rst_n), .req_rd(s_rd), .req_wr(s_wr),
    .req_addr(s_addr), .req_wdata(s_wdata), .acq(s_acq), .rdata(s_rdata),
    .mem_addr(s_maddr), .mem_wdata(s_mwdata), .mem_wren(s_wren),
    .mem_q(s_q), .busy(s_busy), .gnt_id(s_gnt)
  );

  // DRAM models: registered address, q one cycle after the address is clocked in
  logic [7:0] dram4 [256];
  logic [7:0] dram1 [256];
  logic [7:0] ra4, ra1;

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 29 + 11) & 255);
  endfunction

  always @(posedge CLK) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) begin
        dram4[i] <= pat(i);
        dram1[i] <= pat(i);
      end
    end else begin
      if (mem_wren) dram4[mem_addr] <= mem_wdata;
      if (s_wren)   dram1[s_maddr]  <= s_mwdata;
    end
    ra4 <= mem_addr;
    ra1 <= s_maddr;
  end

  assign mem_q = dram4[ra4];
  assign s_q   = dram1[ra1];

  // Reference: memory contents and the round-robin pointer, per the arbitration rules
  logic [7:0] ref4 [256];
  logic [7:0] ref1 [256];
  int         m_last;
  int         n_cmp = 0;
  int         n_err = 0;

  logic [3:0] pend;
  bit         p_wr [4];
  logic [7:0] p_a  [4];
  logic [7:0] p_d  [4];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int c, input bit rd, input bit wr,
                         input logic [7:0] a, input logic [7:0] d);
    req_rd[c] = rd;
    req_wr[c] = wr;
    req_addr[c*AW +: AW]  = a;
    req_wdata[c*DW +: DW] = d;
  endtask

  // Next core in circular order after 'last' that has a pending request.
  function automatic int rr_next(input logic [3:0] p, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (p[(last + k) % 4]) return (last + k) % 4;
    end
    return 0;
  endfunction

  // Called in an IDLE cycle with the request(s) already applied.
  task automatic await_grant(input int w, input bit is_wr, input logic [7:0] a,
                             input logic [7:0] d, input string tag, input bit drop);
    int n, wc;
    bit got;
    n = 0; wc = 0; got = 0;
    while (!got && n < 12) begin
      tick();
      n++;
      if (mem_wren) begin
        wc++;
        chk({tag, "_waddr"}, 32'(mem_addr), 32'(a));
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'(d));
      end
      if (acq != '0) got = 1;
    end
    chk({tag, "_acq"}, 32'(acq), 32'(1) << w);
    chk({tag, "_lat"}, 32'(n), is_wr ? 32'd2 : 32'd3);
    chk({tag, "_wren"}, 32'(wc), is_wr ? 32'd1 : 32'd0);
    chk({tag, "_gnt"}, 32'(gnt_id), 32'(w));
    chk({tag, "_addr_hold"}, 32'(mem_addr), 32'(a));
    if (!is_wr) chk({tag, "_rdata"}, 32'(rdata), 32'(ref4[a]));
    else ref4[a] = d;
    m_last = w;
    if (drop) begin
      req_rd[w] = 1'b0;
      req_wr[w] = 1'b0;
    end
    tick();
    chk({tag, "_acq_off"}, 32'(acq), 32'd0);
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
  endtask

  task automatic xact4(input int c, input bit rd, input bit wr, input logic [7:0] a,
                       input logic [7:0] d, input string tag);
    set_req(c, rd, wr, a, d);
    await_grant(c, wr, a, d, tag, 1'b1);
  endtask

  task automatic xact1(input bit wr, input logic [7:0] a, input logic [7:0] d, input string tag);
    int n;
    n = 0;
    s_rd = !wr; s_wr = wr; s_addr = a; s_wdata = d;
    while (!s_acq && n < 12) begin
      tick();
      n++;
    end
    chk({tag, "_acq"}, 32'(s_acq), 32'd1);
    chk({tag, "_lat"}, 32'(n), wr ? 32'd2 : 32'd3);
    chk({tag, "_gnt"}, 32'(s_gnt), 32'd0);
    chk({tag, "_addr"}, 32'(s_maddr), 32'(a));
    if (!wr) chk({tag, "_rdata"}, 32'(s_rdata), 32'(ref1[a]));
    else ref1[a] = d;
    s_rd = 1'b0; s_wr = 1'b0;
    tick();
    chk({tag, "_busy_off"}, 32'(s_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [7:0] a, d;
    rst_n = 1'b0; init_mem = 1'b1;
    req_rd = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    s_rd = 1'b0; s_wr = 1'b0; s_addr = '0; s_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      ref4[i] = pat(i);
      ref1[i] = pat(i);
    end
    pend = '0;
    tick(); tick();
    init_mem = 1'b0;

    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_acq", 32'(acq), 32'd0);
    chk("rst_wren", 32'(mem_wren), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_gnt", 32'(gnt_id), 32'd0);
    chk("rst1_gnt", 32'(s_gnt), 32'd0);
    rst_n = 1'b1;
    m_last = 3;
    tick();

    xact4(1, 1'b0, 1'b1, 8'h10, 8'h5A, "c1_wr");
    xact4(1, 1'b1, 1'b0, 8'h10, 8'h00, "c1_rd");
    xact4(2, 1'b1, 1'b1, 8'h20, 8'h33, "c2_both");
    xact4(0, 1'b1, 1'b0, 8'h20, 8'h00, "c0_rd20");

    // All four cores hold writes from reset
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) set_req(c, 1'b0, 1'b1, 8'(8'h40 + c), 8'(8'hA0 + c));
    tick(); tick();
    rst_n = 1'b1;
    m_last = 3;
    for (int i = 0; i < 5; i++) begin
      w = rr_next(4'hF, m_last);
      chk("all4_order", 32'(w), 32'(i % 4));
      await_grant(w, 1'b1, 8'(8'h40 + w), 8'(8'hA0 + w), "all4", 1'b0);
    end
    req_rd = '0; req_wr = '0;
    tick();
    xact4(3, 1'b1, 1'b0, 8'h42, 8'h00, "all4_rb");

    // Reset during a read's WAIT cycle
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_last = 3;
    chk("mid_rdata0", 32'(rdata), 32'd0);
    set_req(0, 1'b1, 1'b0, 8'h05, 8'h00);
    tick(); tick();
    chk("mid_busy_wait", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_acq", 32'(acq), 32'd0);
    chk("mid_rdata", 32'(rdata), 32'd0);
    chk("mid_wren", 32'(mem_wren), 32'd0);
    tick();
    chk("mid_acq2", 32'(acq), 32'd0);
    rst_n = 1'b1;
    m_last = 3;
    tick();

    // Randomized concurrent traffic against the round-robin model
    for (int r = 0; r < 60; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!pend[c] && ($urandom_range(0, 2) != 0)) begin
          int kind;
          kind = int'($urandom_range(0, 2));
          a = 8'($urandom_range(0, 15));
          d = 8'($urandom);
          p_wr[c] = (kind != 0);
          p_a[c] = a; p_d[c] = d;
          set_req(c, kind != 1, kind != 0, a, d);
          pend[c] = 1'b1;
        end
      end
      if (pend == '0) begin
        p_wr[0] = 1'b1; p_a[0] = 8'h07; p_d[0] = 8'($urandom);
        set_req(0, 1'b0, 1'b1, p_a[0], p_d[0]);
        pend[0] = 1'b1;
      end
      w = rr_next(pend, m_last);
      await_grant(w, p_wr[w], p_a[w], p_d[w], "rand", 1'b1);
      pend[w] = 1'b0;
    end
    req_rd = '0; req_wr = '0; pend = '0;
    tick(); tick(); tick();

    // Single-core instance: boundary addresses, then random mix
    xact1(1'b1, 8'hFF, 8'hC3, "s_wrFF");
    xact1(1'b0, 8'hFF, 8'h00, "s_rdFF");
    xact1(1'b0, 8'h00, 8'h00, "s_rd00");
    for (int r = 0; r < 10; r++) begin
      a = 8'($urandom_range(0, 7));
      d = 8'($urandom);
      xact1(1'($urandom_range(0, 1)), a, d, "s_rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Parametrised shared-data-memory arbiter for the multi-core processor build. It sits between `N_CORES` processor cores and one single-port DRAM instance. Each core's load/store request is granted in round-robin order, the single DRAM access is sequenced, and completion is signalled back on that core's `acq` line together with read data. With `N_CORES=1` it degenerates to a fixed-latency wrapper around one core's data port.

## Interface
- `N_CORES`, 4: number of requesting cores, 1..8.
- `AW`, 8: data address width.
- `DW`, 8: data word width.

Ports:
- `CLK`  in  1: system clock (divided clock from the clock divider).
- `rst_n`  in  1: reset, synchronous, active-low.
- `req_rd`  in  N_CORES: per-core read request, held until that core's `acq`.
- `req_wr`  in  N_CORES: per-core write request (core `Mem_Ctrl[1]`), held until `acq`.
- `req_addr`  in  N_CORES*AW: packed addresses, core i at `[i*AW +: AW]`.
- `req_wdata`  in  N_CORES*DW: packed write data, same packing.
- `acq`  out  N_CORES: one-cycle completion pulse to the granted core.
- `rdata`  out  DW: read data, common to all cores, valid while `acq` is high.
- `mem_addr`  out  AW: to DRAM `address`.
- `mem_wdata`  out  DW: to DRAM `data`.
- `mem_wren`  out  1: to DRAM `wren`.
- `mem_q`  in  DW: from DRAM `q`. Read data appears 1 cycle after the address is clocked in.
- `busy`  out  1: high whenever the FSM is not in IDLE (LED debug).
- `gnt_id`  out  clog2(N_CORES) (min 1): index of the current or last granted core (HEX debug).

## Operation
- FSM states: IDLE, ACCESS, WAIT, ACK.
- IDLE:
  - Form `req = req_rd | req_wr`.
  - If nonzero, pick the winner by round-robin starting at `(last+1) mod N_CORES`.
  - Register the winner, its address and its data. `op = write` if the winner's `req_wr` is set, else read.
  - Update `last`. Go to ACCESS.
- ACCESS:
  - `mem_addr`/`mem_wdata` driven from the registered request.
  - `mem_wren = 1` only for a write.
  - Next state is ACK for a write, WAIT for a read.
- WAIT: `mem_q` is valid. Capture it into the `rdata` register, then go to ACK.
- ACK: `acq[gnt_id] = 1` for exactly this cycle, all other `acq` bits 0. Return to IDLE.
- Both `req_rd` and `req_wr` high for the same core: the write is performed, the read is dropped, and a single `acq` is given.
- A core must drop its request in the cycle after `acq`. A request still high when the FSM re-enters IDLE is a new request. Round-robin prevents that core from starving others.
- `rdata` holds its value until the next read completes. Writes do not alter it.
- Requests arriving while the FSM is not IDLE are ignored until IDLE. No queueing.
- Round-robin pointer wraps from `N_CORES-1` to 0.
- All outputs are registered.

## Timing
- Reset values: state IDLE, `acq=0`, `mem_wren=0`, `mem_addr=0`, `mem_wdata=0`, `rdata=0`, `busy=0`, `gnt_id=0`, `last=N_CORES-1` (so core 0 wins first).
- Write latency: request sampled in IDLE at cycle t. `mem_wren=1` during t+1. `acq` during t+2. Throughput is 1 write per 3 cycles.
- Read latency: request sampled at t. Address presented t+1. `mem_q` captured t+2. `acq` and valid `rdata` during t+3. Throughput is 1 read per 4 cycles.
- `mem_wren` is never high outside ACCESS.
- `mem_addr` is stable from ACCESS through ACK.
- Reset asserted mid-operation takes effect on the next edge:
  - State returns to IDLE and `mem_wren` drops.
  - No `acq` is issued for the aborted access.
  - A write already clocked into DRAM is not undone.
- `N_CORES=1`: `gnt_id` is constant 0 and behaviour is otherwise identical.

## Structure
- Package `arb_pkg`:
  - state enum `{IDLE, ACCESS, WAIT, ACK}`;
  - `IDW = (N_CORES>1) ? $clog2(N_CORES) : 1` helper;
  - `READ_LAT = 1` constant.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req[N_CORES]`, `last`.
  - Outputs: `winner` index, `any`.
  - Rotate-then-priority-encode implementation.
- FSM, request registers and `rdata` register live in `dram_arbiter`. The top level instantiates one arbiter plus the DRAM.

## Test plan
- Reset, then core 1 writes `0x5A` to address `0x10`: `mem_wren=1` for exactly one cycle with `mem_addr=0x10`, `mem_wdata=0x5A`. `acq=4'b0010` two cycles after sampling.
- Core 1 then reads `0x10`: `acq[1]` 3 cycles after sampling, with `rdata=0x5A`.
- All 4 cores hold write requests from reset: grants go 0,1,2,3,0 in that order, each `acq` 3 cycles apart, and no core is granted twice before all others.
- Core 2 asserts both `req_rd` and `req_wr` (addr `0x20`, data `0x33`): one write and a single `acq[2]`. A subsequent read of `0x20` returns `0x33`.
- `rst_n` pulled low during a read's WAIT cycle: next cycle `busy=0`, `acq=0`, `rdata` unchanged at its reset value `0x00`.
- `N_CORES=1`, back-to-back reads of addresses `0xFF` then `0x00`: address wraps correctly, `gnt_id=0`, each read completes in 4 cycles.
